// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - 9-bit word to 2-bit serial converter with COM fill
// Optional COM training burst after reset is enabled by defining PS_TX_TRAINING_EN.
module paralelo_serial_tx #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         TRAIN_SYMS = 4
) (
    input  logic       clk_16,
    input  logic       reset,
    input  logic [8:0] data_in,
    output logic [1:0] serial,
    output logic       load,
    output logic       tx_active
);

    typedef enum logic {S_TRAIN, S_DATA} state_t;

    if (TRAIN_SYMS < 0 || TRAIN_SYMS > 255) begin : g_bad_train_syms
        $error("TRAIN_SYMS must be in 0..255");
    end

    logic [1:0] r_ph;
    logic [7:0] r_sym;
    logic [7:0] w_sel;
    state_t     w_state;
    state_t     w_state_next;

`ifdef PS_TX_TRAINING_EN
    localparam state_t     RST_STATE  = (TRAIN_SYMS == 0) ? S_DATA : S_TRAIN;
    localparam logic [7:0] TRAIN_LAST = 8'((TRAIN_SYMS == 0) ? 0 : TRAIN_SYMS - 1);

    state_t     r_state;
    logic [7:0] r_train_cnt;
    logic [7:0] w_train_cnt_next;

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            r_state     <= RST_STATE;
            r_train_cnt <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_train_cnt <= w_train_cnt_next;
        end
    end

    assign w_state = r_state;

    always_comb begin
        w_state_next     = r_state;
        w_train_cnt_next = r_train_cnt;
        if (r_state == S_TRAIN && r_ph == 2'd0) begin
            w_train_cnt_next = r_train_cnt + 8'd1;
            if (r_train_cnt == TRAIN_LAST) begin
                w_state_next = S_DATA;
            end
        end
    end
`else
    assign w_state      = S_DATA;
    assign w_state_next = S_DATA;
`endif

    // Invalid words and training slots both become COM so the link never idles.
    always_comb begin
        w_sel = COM;
        load  = (w_state == S_DATA) && (r_ph == 2'd0);
        if (w_state == S_DATA && data_in[8]) begin
            w_sel = data_in[7:0];
        end
    end

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            r_ph      <= 2'd0;
            r_sym     <= 8'h00;
            serial    <= 2'b00;
            tx_active <= 1'b0;
        end else begin
            r_ph      <= r_ph + 2'd1;
            tx_active <= (w_state_next == S_DATA);
            case (r_ph)
                2'd0: begin
                    r_sym  <= w_sel;
                    serial <= w_sel[7:6];
                end
                2'd1:    serial <= r_sym[5:4];
                2'd2:    serial <= r_sym[3:2];
                default: serial <= r_sym[1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - scoreboard bench for paralelo_serial_tx
module tb_paralelo_serial_tx;

    localparam logic [7:0] COM = 8'hBC;
    localparam int TRAIN_SYMS  = 4;
`ifdef PS_TX_TRAINING_EN
    localparam int NT = TRAIN_SYMS;
`else
    localparam int NT = 0;
`endif
    localparam int NV = 11;

    typedef struct {
        logic [8:0] din;
        logic [7:0] exp;
    } vec_t;

    logic       clk_16 = 1'b0;
    logic       rst_n;
    logic [8:0] data_in;
    logic [1:0] serial;
    logic       load;
    logic       tx_active;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[NV];
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    paralelo_serial_tx #(.COM(COM), .TRAIN_SYMS(TRAIN_SYMS)) dut (
        .clk_16    (clk_16),
        .reset     (rst_n),
        .data_in   (data_in),
        .serial    (serial),
        .load      (load),
        .tx_active (tx_active)
    );

    always #5 clk_16 = ~clk_16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_16) begin
        #1;
        if (!rst_n) begin
            mon_cnt = 0;
        end else begin
            mon_byte = {mon_byte[5:0], serial};
            mon_cnt++;
            if (mon_cnt == 4) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("symbol_unexpected", {24'h0, mon_byte}, 32'hFFFF_FFFF);
                end else begin
                    chk("symbol", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    function automatic logic exp_load(input int k);
        return (k % 4 == 0) && (k >= 4 * NT);
    endfunction

    function automatic logic exp_txa(input int k);
        return (NT == 0) ? (k >= 1) : (k >= 4 * (NT - 1) + 1);
    endfunction

    // Entered at the negedge where reset was released; k counts rising edges since then.
    task automatic run(input int ncyc);
        int s;
        for (int k = 0; k < ncyc; k++) begin
            chk("load", {31'h0, load}, {31'h0, exp_load(k)});
            chk("tx_active", {31'h0, tx_active}, {31'h0, exp_txa(k)});
            if (k % 4 == 0) begin
                s = k / 4;
                if (s < NT) begin
                    data_in = 9'h1A5;
                    exp_q.push_back(COM);
                end else begin
                    data_in = vecs[(s - NT) % NV].din;
                    exp_q.push_back(vecs[(s - NT) % NV].exp);
                end
            end else begin
                data_in = 9'h100;
            end
            @(negedge clk_16);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_serial"}, {30'h0, serial}, 32'h0);
        chk({tag, "_tx_active"}, {31'h0, tx_active}, 32'h0);
        chk({tag, "_load"}, {31'h0, load}, (NT == 0) ? 32'h1 : 32'h0);
    endtask

    initial begin
        vecs[0]  = '{9'h15A, 8'h5A};
        vecs[1]  = '{9'h1A5, 8'hA5};
        vecs[2]  = '{9'h1A5, 8'hA5};
        vecs[3]  = '{9'h13C, 8'h3C};
        vecs[4]  = '{9'h0FF, 8'hBC};
        vecs[5]  = '{9'h13C, 8'h3C};
        vecs[6]  = '{9'h0FF, 8'hBC};
        vecs[7]  = '{9'h181, 8'h81};
        vecs[8]  = '{9'h181, 8'h81};
        vecs[9]  = '{9'h000, 8'hBC};
        vecs[10] = '{9'h100, 8'h00};

        rst_n   = 1'b0;
        data_in = 9'h000;
        repeat (3) @(negedge clk_16);
        check_reset_outputs("por");

        rst_n = 1'b1;
        run(4 * (NT + NV));
        chk("queue_drained", exp_q.size(), 32'h0);

        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_16);
        rst_n = 1'b1;
        run(4 * (NT + 2) + 2);

        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk_16);
        check_reset_outputs("mid_reset_hold");

        rst_n = 1'b1;
        run(4 * (NT + NV));
        chk("queue_drained_2", exp_q.size(), 32'h0);

        rst_n = 1'b0;
        @(negedge clk_16);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
